// File: rtl/divconv_pkg.sv
// rtl/divconv_pkg.sv - shared state encoding, mux selects and control decode for the Goldschmidt divider controller
package divconv_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT_D = 3'd1,
    S_INIT_N = 3'd2,
    S_ITER_N = 3'd3,
    S_ITER_D = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] MUXA_REGA = 2'd0;
  localparam logic [1:0] MUXA_D    = 2'd1;
  localparam logic [1:0] MUXA_IA   = 2'd2;

  localparam logic [1:0] MUXB_D    = 2'd0;
  localparam logic [1:0] MUXB_X    = 2'd1;
  localparam logic [1:0] MUXB_REGB = 2'd2;
  localparam logic [1:0] MUXB_REGC = 2'd3;

  typedef struct packed {
    logic [1:0] sel_muxa;
    logic [1:0] sel_muxb;
    logic       load_rega;
    logic       load_regb;
    logic       load_regc;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Moore decode: datapath controls depend on the state register alone
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '{sel_muxa: MUXA_REGA, sel_muxb: MUXB_D, default: 1'b0};
    case (s)
      S_INIT_D: begin
        c.sel_muxa  = MUXA_IA;
        c.sel_muxb  = MUXB_D;
        c.load_regb = 1'b1;
        c.load_rega = 1'b1;
        c.busy      = 1'b1;
      end
      S_INIT_N: begin
        c.sel_muxa  = MUXA_IA;
        c.sel_muxb  = MUXB_X;
        c.load_regc = 1'b1;
        c.busy      = 1'b1;
      end
      S_ITER_N: begin
        c.sel_muxa  = MUXA_REGA;
        c.sel_muxb  = MUXB_REGC;
        c.load_regc = 1'b1;
        c.busy      = 1'b1;
      end
      S_ITER_D: begin
        c.sel_muxa  = MUXA_REGA;
        c.sel_muxb  = MUXB_REGB;
        c.load_regb = 1'b1;
        c.load_rega = 1'b1;
        c.busy      = 1'b1;
      end
      S_DONE:  c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/divconv_ctrl.sv
// rtl/divconv_ctrl.sv - Goldschmidt divide sequencer: steps the datapath and captures the final rounded quotient
module divconv_ctrl
  import divconv_pkg::*;
#(
  parameter int ITERS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] q,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       load_rega,
  output logic       load_regb,
  output logic       load_regc,
  output logic       busy,
  output logic       done,
  output logic [7:0] quot
);

  if (ITERS < 1 || ITERS > 7) begin : g_bad_iters
    $error("divconv_ctrl: ITERS must be within 1..7");
  end

  localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quot_q, quot_d;
  ctrl_t      ctrl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_INIT_D;
      S_INIT_D: state_d = S_INIT_N;
      S_INIT_N: begin
        cnt_d   = 3'd0;
        state_d = S_ITER_N;
      end
      // N is refined before D so the current K is used before ITER_D overwrites it
      S_ITER_N: begin
        if (cnt_q == LAST_ITER) begin
          quot_d  = q;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER_D;
        end
      end
      S_ITER_D: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = S_ITER_N;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      quot_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
    end
  end

  assign ctrl      = decode_ctrl(state_q);
  assign sel_muxa  = ctrl.sel_muxa;
  assign sel_muxb  = ctrl.sel_muxb;
  assign load_rega = ctrl.load_rega;
  assign load_regb = ctrl.load_regb;
  assign load_regc = ctrl.load_regc;
  assign busy      = ctrl.busy;
  assign done      = ctrl.done;
  assign quot      = quot_q;

endmodule

// File: tb/tb_divconv_ctrl.sv
// tb/tb_divconv_ctrl.sv - scoreboard bench for divconv_ctrl with ITERS=3 and ITERS=1 instances
module tb_divconv_ctrl;

  typedef enum int {P_IDLE, P_INIT_D, P_INIT_N, P_ITER_N, P_ITER_D, P_DONE} phase_t;

  logic       clk = 1'b0;
  logic       reset, start, start1;
  logic [7:0] q;

  logic [1:0] sel_muxa3, sel_muxb3, sel_muxa1, sel_muxb1;
  logic       load_rega3, load_regb3, load_regc3, busy3, done3;
  logic       load_rega1, load_regb1, load_regc1, busy1, done1;
  logic [7:0] quot3, quot1;

  int n_checks = 0;
  int n_errors = 0;

  phase_t     exp3_q[$], exp1_q[$];
  logic [7:0] quot3_sb[$], quot1_sb[$];
  logic [7:0] exp_quot3 = 8'h00;
  logic [7:0] exp_quot1 = 8'h00;

  always #5 clk = ~clk;

  divconv_ctrl #(.ITERS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .q(q),
    .sel_muxa(sel_muxa3), .sel_muxb(sel_muxb3),
    .load_rega(load_rega3), .load_regb(load_regb3), .load_regc(load_regc3),
    .busy(busy3), .done(done3), .quot(quot3)
  );

  divconv_ctrl #(.ITERS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .q(q),
    .sel_muxa(sel_muxa1), .sel_muxb(sel_muxb1),
    .load_rega(load_rega1), .load_regb(load_regb1), .load_regc(load_regc1),
    .busy(busy1), .done(done1), .quot(quot1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {sel_muxa, sel_muxb, load_rega, load_regb, load_regc, busy, done}
  function automatic logic [8:0] exp_vec(input phase_t p);
    case (p)
      P_INIT_D: return 9'b10_00_110_10;
      P_INIT_N: return 9'b10_01_001_10;
      P_ITER_N: return 9'b00_11_001_10;
      P_ITER_D: return 9'b00_10_110_10;
      P_DONE:   return 9'b00_00_000_01;
      default:  return 9'b00_00_000_00;
    endcase
  endfunction

  // selects are don't-care in DONE
  function automatic logic [8:0] exp_mask(input phase_t p);
    return (p == P_DONE) ? 9'b00_00_111_11 : 9'h1FF;
  endfunction

  always @(negedge clk) begin
    phase_t     p;
    logic [8:0] got;
    p   = (exp3_q.size() > 0) ? exp3_q.pop_front() : P_IDLE;
    got = {sel_muxa3, sel_muxb3, load_rega3, load_regb3, load_regc3, busy3, done3};
    check_eq($sformatf("dut3_ctrl_%s", p.name()), 32'(got & exp_mask(p)), 32'(exp_vec(p) & exp_mask(p)));
    if (p == P_DONE) begin
      if (quot3_sb.size() > 0) exp_quot3 = quot3_sb.pop_front();
      else check_eq("dut3_sb_underflow", 32'd1, 32'd0);
    end
    check_eq("dut3_quot", 32'(quot3), 32'(exp_quot3));
  end

  always @(negedge clk) begin
    phase_t     p;
    logic [8:0] got;
    p   = (exp1_q.size() > 0) ? exp1_q.pop_front() : P_IDLE;
    got = {sel_muxa1, sel_muxb1, load_rega1, load_regb1, load_regc1, busy1, done1};
    check_eq($sformatf("dut1_ctrl_%s", p.name()), 32'(got & exp_mask(p)), 32'(exp_vec(p) & exp_mask(p)));
    if (p == P_DONE) begin
      if (quot1_sb.size() > 0) exp_quot1 = quot1_sb.pop_front();
      else check_eq("dut1_sb_underflow", 32'd1, 32'd0);
    end
    check_eq("dut1_quot", 32'(quot1), 32'(exp_quot1));
  end

  // Raise start and push the whole expected cycle sequence plus the quotient
  task automatic launch(input bit one, input logic [7:0] qf);
    int iters;
    iters = one ? 1 : 3;
    if (one) start1 = 1'b1;
    else     start  = 1'b1;
    for (int k = 0; k < 2 * iters + 2; k++) begin
      phase_t p;
      if (k == 0)                   p = P_INIT_D;
      else if (k == 1)              p = P_INIT_N;
      else if (k == 2 * iters + 1)  p = P_DONE;
      else if (k % 2 == 0)          p = P_ITER_N;
      else                          p = P_ITER_D;
      if (one) exp1_q.push_back(p);
      else     exp3_q.push_back(p);
    end
    if (one) quot1_sb.push_back(qf);
    else     quot3_sb.push_back(qf);
  endtask

  // q carries the wanted quotient only in the final ITER_N cycle
  task automatic drive_run(input bit one, input logic [7:0] qf, input bit drop);
    int n;
    n = one ? 4 : 8;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk); #1;
      if (drop && c == 1) begin
        if (one) start1 = 1'b0;
        else     start  = 1'b0;
      end
      q = (c == n - 1) ? qf : ~qf;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      q = 8'($urandom);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    q      = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;

    launch(1'b0, 8'h5A);
    drive_run(1'b0, 8'h5A, 1'b1);
    idle(4);

    @(negedge clk); #1;
    launch(1'b0, 8'hC3);
    drive_run(1'b0, 8'hC3, 1'b0);
    @(negedge clk); #1;
    launch(1'b0, 8'h3C);
    drive_run(1'b0, 8'h3C, 1'b1);
    idle(3);

    @(negedge clk); #1;
    launch(1'b0, 8'h99);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      if (c == 1) start = 1'b0;
      q = 8'h99;
    end
    reset = 1'b1;
    exp3_q.delete();
    quot3_sb.delete();
    exp_quot3 = 8'h00;
    exp1_q.delete();
    quot1_sb.delete();
    exp_quot1 = 8'h00;
    @(negedge clk); #1;
    reset = 1'b0;
    launch(1'b0, 8'hA7);
    drive_run(1'b0, 8'hA7, 1'b1);
    idle(2);

    for (int i = 0; i < 3; i++) begin
      logic [7:0] qf;
      qf = 8'($urandom);
      @(negedge clk); #1;
      launch(1'b0, qf);
      drive_run(1'b0, qf, 1'b1);
      idle(2);
    end

    for (int i = 0; i < 3; i++) begin
      logic [7:0] qf;
      qf = (i == 0) ? 8'h5A : 8'($urandom);
      @(negedge clk); #1;
      launch(1'b1, qf);
      drive_run(1'b1, qf, 1'b1);
      idle(3);
    end

    @(negedge clk); #1;
    launch(1'b1, 8'h81);
    drive_run(1'b1, 8'h81, 1'b0);
    start1 = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/divconv_ctrl.md
DIVCONV_CTRL -- requirements
Module: divconv_ctrl

Interface
REQ-001 Parameter: ITERS, default 3, number of Goldschmidt refinement iterations (legal range 1..7).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 q  input  8  rounded product from the divide datapath; quotient source on final step.
REQ-006 sel_muxa  output  2  datapath A-mux select: 0=rega_out, 1=d, 2=initial approximation.
REQ-007 sel_muxb  output  2  datapath B-mux select: 0=d, 1=x, 2=regb_out, 3=regc_out.
REQ-008 load_rega  output  1  load 2's-complement factor register (K = 2 - D).
REQ-009 load_regb  output  1  load denominator register.
REQ-010 load_regc  output  1  load numerator register.
REQ-011 busy  output  1  high from INIT_D through the final ITER_N inclusive.
REQ-012 done  output  1  one-cycle pulse; quot valid while high and held until next capture.
REQ-013 quot  output  8  registered quotient.

Function
REQ-014 States SHALL be IDLE, INIT_D, INIT_N, ITER_N, ITER_D, DONE; sel/load/busy/done decoded combinationally from the state register only (Moore).
REQ-015 IDLE: sel_muxa=0, sel_muxb=0, all loads 0; start=1 -> INIT_D, else stay.
REQ-016 INIT_D: sel_muxa=2, sel_muxb=0, load_regb=1, load_rega=1 (D1=ia*d, K=2-D1); -> INIT_N.
REQ-017 INIT_N: sel_muxa=2, sel_muxb=1, load_regc=1 (N1=ia*x); clear iteration counter; -> ITER_N.
REQ-018 ITER_N: sel_muxa=0, sel_muxb=3, load_regc=1 (N=K*N); if counter==ITERS-1 -> DONE and capture q into quot at that edge, else -> ITER_D.
REQ-019 ITER_D: sel_muxa=0, sel_muxb=2, load_regb=1, load_rega=1 (D=K*D, K=2-D); counter+1; -> ITER_N.
REQ-020 ITER_N SHALL always precede ITER_D within an iteration so K is consumed by N before being overwritten.
REQ-021 DONE: all loads 0, done=1; -> IDLE unconditionally; start in DONE ignored.
REQ-022 Latency: done high exactly 2*ITERS+2 cycles after the edge sampling start (8 for ITERS=3).
REQ-023 start while busy or in DONE SHALL be ignored; no restart, no queuing.
REQ-024 Counter 3 bits, never wraps for legal ITERS; ITERS outside 1..7 is illegal (elaboration assertion).
REQ-025 Upstream SHALL hold d and x stable from start until done; controller does not register them.
REQ-026 Exactly one of {load_regb&load_rega, load_regc} active per busy cycle; never all three.

Reset
REQ-027 reset=1 SHALL asynchronously force IDLE, counter=0, quot=8'h00; hence all loads 0, selects 0, busy=0, done=0.
REQ-028 Reset mid-operation abandons the division; no done pulse; quot reads 8'h00 after reset.
REQ-029 First start is accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package divconv_pkg SHALL hold the state enum and select constants (MUXA_REGA=0, MUXA_D=1, MUXA_IA=2; MUXB_D=0, MUXB_X=1, MUXB_REGB=2, MUXB_REGC=3).
REQ-031 Single module, no sub-modules; the 8-bit register primitive used by the datapath MAY be reused for quot.

Verification
REQ-032 ITERS=3, 1-cycle start pulse -> state/outputs INIT_D,INIT_N,ITER_N,ITER_D,ITER_N,ITER_D,ITER_N,DONE, selects/loads per REQ-016..019; done in cycle 8.
REQ-033 Drive q=8'h5A during final ITER_N only (other values elsewhere) -> quot=8'h5A with done, held at 8'h5A through later IDLE cycles.
REQ-034 start held high in cycles 2..9 -> exactly one done (cycle 8); new run begins only after returning to IDLE.
REQ-035 Assert reset during second ITER_D -> next cycle busy=0, all loads 0, quot=8'h00, no done pulse.
REQ-036 ITERS=1 -> sequence INIT_D,INIT_N,ITER_N,DONE; done in cycle 4; no ITER_D ever.
REQ-037 Integrated with divide datapath, sweep d,x over all positive operands -> quot matches bit-accurate Goldschmidt model exactly for ITERS=3.
